// File: rtl/data_mem_resp_if.sv
// ----------------------------------------------------------------------------
// data_mem_resp_if
// Request/response bundle between a requester and the data_mem_resp memory.
//
// Signals (widths fixed: 32-bit byte address, 32-bit data, 3-bit type code)
//   mem_enable_i    request strobe
//   w_mem_enable_i  write request
//   w_mem_addr_i    byte address for the write
//   w_mem_data_i    write data, LSB-aligned
//   r_mem_enable_i  read request
//   r_mem_addr_i    byte address for the read
//   data_type_i     access size code (0 byte, 1 half, 2 word, 4 ubyte, 5 uhalf)
//   r_mem_data_o    read data, LSB-aligned
//   mem_ready_o     one-cycle response pulse
//   mem_busy_o      high while a request is in flight
//   mem_err_o       error flag, valid with mem_ready_o
//
// Modports: master = requester side, slave = memory side.
// ----------------------------------------------------------------------------
interface data_mem_resp_if;
   logic        mem_enable_i;
   logic        w_mem_enable_i;
   logic [31:0] w_mem_addr_i;
   logic [31:0] w_mem_data_i;
   logic        r_mem_enable_i;
   logic [31:0] r_mem_addr_i;
   logic [2:0]  data_type_i;
   logic [31:0] r_mem_data_o;
   logic        mem_ready_o;
   logic        mem_busy_o;
   logic        mem_err_o;

   modport master (
      output mem_enable_i, w_mem_enable_i, w_mem_addr_i, w_mem_data_i,
      output r_mem_enable_i, r_mem_addr_i, data_type_i,
      input  r_mem_data_o, mem_ready_o, mem_busy_o, mem_err_o
   );

   modport slave (
      input  mem_enable_i, w_mem_enable_i, w_mem_addr_i, w_mem_data_i,
      input  r_mem_enable_i, r_mem_addr_i, data_type_i,
      output r_mem_data_o, mem_ready_o, mem_busy_o, mem_err_o
   );
endinterface

// File: rtl/data_mem_resp.sv
// ----------------------------------------------------------------------------
// data_mem_resp
// Single-port data memory with a three-state request/response handshake:
// IDLE -> ACCESS -> RESP -> IDLE, one request in flight. A request accepted in
// IDLE is captured; the array is read and the write committed at the end of
// ACCESS (so a combined read+write returns pre-write data); the response is
// presented with a one-cycle mem_ready_o pulse during RESP.
//
// Ports
//   clk  single clock, rising edge
//   rst  synchronous active-high reset (memory array is not cleared)
//   bus  data_mem_resp_if.slave (request inputs, response outputs)
//
// Parameter
//   DEPTH_WORDS  number of 32-bit words, power of two, >= 4
//
// Optional feature macro: DATA_MEM_RESP_BYTE_LANE_EN
//   defined   : byte/half lane writes, shifted and extended reads, alignment
//               check on half/word accesses
//   undefined : addr[1:0] ignored, full-word write and raw-word read for all
//               valid type codes
// ----------------------------------------------------------------------------
module data_mem_resp #(
   parameter int DEPTH_WORDS = 1024
) (
   input logic           clk,
   input logic           rst,
   data_mem_resp_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [2:0] T_BYTE  = 3'd0;
   localparam logic [2:0] T_HALF  = 3'd1;
   localparam logic [2:0] T_WORD  = 3'd2;
   localparam logic [2:0] T_UBYTE = 3'd4;
   localparam logic [2:0] T_UHALF = 3'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_r;
   logic        w_en_r;
   logic        r_en_r;
   logic [31:0] w_addr_r;
   logic [31:0] w_data_r;
   logic [31:0] r_addr_r;
   logic [2:0]  dtype_r;
   logic [31:0] r_data_r;
   logic        ready_r;
   logic        busy_r;
   logic        err_r;

   logic [31:0] mem_r [DEPTH_WORDS];

   logic [IDX_W-1:0] w_idx_s;
   logic [IDX_W-1:0] r_idx_s;
   logic             type_ok_s;
   logic             w_bad_s;
   logic             r_bad_s;
   logic             err_s;
   logic             do_write_s;
   logic [31:0]      rd_word_s;
   logic [31:0]      rd_data_s;
   logic [31:0]      wr_word_s;

`ifdef DATA_MEM_RESP_BYTE_LANE_EN
   // Half accesses need an even address, word accesses a 4-byte aligned one.
   function automatic logic misaligned(input logic [1:0] off, input logic [2:0] dtype);
      logic mis;
      case (dtype)
         T_HALF, T_UHALF: mis = off[0];
         T_WORD:          mis = (off != 2'b00);
         default:         mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Replace only the addressed lanes of the stored word.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  dtype);
      logic [31:0] word;
      word = old_word;
      case (dtype)
         T_BYTE, T_UBYTE: word[{off, 3'b000} +: 8]         = wdata[7:0];
         T_HALF, T_UHALF: word[{off[1], 4'b0000} +: 16]    = wdata[15:0];
         T_WORD:          word                             = wdata;
         default:         word                             = old_word;
      endcase
      return word;
   endfunction

   // Shift the addressed lanes down to bit 0 and extend to 32 bits.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  dtype);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (dtype)
         T_BYTE:  res = {{24{sh[7]}}, sh[7:0]};
         T_UBYTE: res = {24'd0, sh[7:0]};
         T_HALF:  res = {{16{sh[15]}}, sh[15:0]};
         T_UHALF: res = {16'd0, sh[15:0]};
         T_WORD:  res = sh;
         default: res = 32'd0;
      endcase
      return res;
   endfunction
`else
   // Byte offsets carry no meaning when lanes are disabled.
   logic unused_offset_bits_s;
   assign unused_offset_bits_s = ^{w_addr_r[1:0], r_addr_r[1:0]};
`endif

   // Decode the captured request: indices, error conditions, read and write words.
   always_comb begin
      w_idx_s = w_addr_r[IDX_W+1:2];
      r_idx_s = r_addr_r[IDX_W+1:2];

      case (dtype_r)
         T_BYTE, T_HALF, T_WORD, T_UBYTE, T_UHALF: type_ok_s = 1'b1;
         default:                                  type_ok_s = 1'b0;
      endcase

      // Any address bit above the index field means addr >= 4*DEPTH_WORDS.
`ifdef DATA_MEM_RESP_BYTE_LANE_EN
      w_bad_s = ((w_addr_r >> (IDX_W + 2)) != 32'd0) || misaligned(w_addr_r[1:0], dtype_r);
      r_bad_s = ((r_addr_r >> (IDX_W + 2)) != 32'd0) || misaligned(r_addr_r[1:0], dtype_r);
`else
      w_bad_s = ((w_addr_r >> (IDX_W + 2)) != 32'd0);
      r_bad_s = ((r_addr_r >> (IDX_W + 2)) != 32'd0);
`endif

      // Any error kills the whole request: no write and zero read data.
      err_s      = !type_ok_s || (w_en_r && w_bad_s) || (r_en_r && r_bad_s);
      do_write_s = w_en_r && !err_s;
      rd_word_s  = mem_r[r_idx_s];

      if (r_en_r && !err_s) begin
`ifdef DATA_MEM_RESP_BYTE_LANE_EN
         rd_data_s = lane_extract(rd_word_s, r_addr_r[1:0], dtype_r);
`else
         rd_data_s = rd_word_s;
`endif
      end else begin
         rd_data_s = 32'd0;
      end

`ifdef DATA_MEM_RESP_BYTE_LANE_EN
      wr_word_s = lane_merge(mem_r[w_idx_s], w_data_r, w_addr_r[1:0], dtype_r);
`else
      wr_word_s = w_data_r;
`endif
   end

   // Request FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         w_en_r   <= 1'b0;
         r_en_r   <= 1'b0;
         w_addr_r <= 32'd0;
         w_data_r <= 32'd0;
         r_addr_r <= 32'd0;
         dtype_r  <= 3'd0;
         r_data_r <= 32'd0;
         ready_r  <= 1'b0;
         busy_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               if (bus.mem_enable_i && (bus.w_mem_enable_i || bus.r_mem_enable_i)) begin
                  w_en_r   <= bus.w_mem_enable_i;
                  r_en_r   <= bus.r_mem_enable_i;
                  w_addr_r <= bus.w_mem_addr_i;
                  w_data_r <= bus.w_mem_data_i;
                  r_addr_r <= bus.r_mem_addr_i;
                  dtype_r  <= bus.data_type_i;
                  busy_r   <= 1'b1;
                  state_r  <= ACCESS;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               r_data_r <= rd_data_s;
               err_r    <= err_s;
               ready_r  <= 1'b1;
               state_r  <= RESP;
            end
            RESP: begin
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Array write at the end of ACCESS; a coinciding reset cancels it.
   always_ff @(posedge clk) begin
      if (!rst && (state_r == ACCESS) && do_write_s) begin
         mem_r[w_idx_s] <= wr_word_s;
      end
   end

   assign bus.r_mem_data_o = r_data_r;
   assign bus.mem_ready_o  = ready_r;
   assign bus.mem_busy_o   = busy_r;
   assign bus.mem_err_o    = err_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// ----------------------------------------------------------------------------
// tb_data_mem_resp
// Self-checking bench for data_mem_resp: directed vector table, hand-written
// reset / held-enable sequences, and random requests against a word-array
// reference model. Follows DATA_MEM_RESP_BYTE_LANE_EN for expected values.
// ----------------------------------------------------------------------------
module tb_data_mem_resp;
   localparam int DEPTH = 64;
`ifdef DATA_MEM_RESP_BYTE_LANE_EN
   localparam bit LANE = 1'b1;
`else
   localparam bit LANE = 1'b0;
`endif
   localparam logic [2:0] DT_B = 3'd0, DT_H = 3'd1, DT_W = 3'd2, DT_BU = 3'd4, DT_HU = 3'd5;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] model_mem [DEPTH];

   data_mem_resp_if bus ();
   data_mem_resp #(.DEPTH_WORDS(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] ra;
      logic [2:0]  dt;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: specification rules in plain arithmetic on a word array.
   task automatic model_req(input logic we, input logic re, input logic [31:0] wa,
                            input logic [31:0] wd, input logic [31:0] ra, input logic [2:0] dt,
                            output logic [31:0] edata, output logic eerr);
      int unsigned size, off;
      logic [31:0] v, mask;
      bit bad;
      bad  = !(dt == 3'd0 || dt == 3'd1 || dt == 3'd2 || dt == 3'd4 || dt == 3'd5);
      size = (dt == 3'd0 || dt == 3'd4) ? 1 : ((dt == 3'd1 || dt == 3'd5) ? 2 : 4);
      if (we && (wa >= 4 * DEPTH)) bad = 1'b1;
      if (re && (ra >= 4 * DEPTH)) bad = 1'b1;
      if (LANE && we && (wa % size != 0)) bad = 1'b1;
      if (LANE && re && (ra % size != 0)) bad = 1'b1;
      edata = 32'd0;
      eerr  = bad;
      if (!bad && re) begin
         v = model_mem[ra / 4];
         if (LANE) begin
            off = ra % 4;
            v = v >> (8 * off);
            if (size == 1) begin
               v = v & 32'h0000_00FF;
               if (dt == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
               v = v & 32'h0000_FFFF;
               if (dt == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
         end
         edata = v;
      end
      if (!bad && we) begin
         if (LANE) begin
            off  = wa % 4;
            mask = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * size)) - 64'd1) << (8 * off);
            model_mem[wa / 4] = (model_mem[wa / 4] & ~mask) | ((wd << (8 * off)) & mask);
         end else begin
            model_mem[wa / 4] = wd;
         end
      end
   endtask

   // One request with handshake timing checks; returns the RESP-cycle data/err.
   task automatic issue(input logic we, input logic re, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [31:0] ra, input logic [2:0] dt,
                        output logic [31:0] rdata, output logic rerr);
      @(negedge clk);
      bus.mem_enable_i   = 1'b1;
      bus.w_mem_enable_i = we;
      bus.r_mem_enable_i = re;
      bus.w_mem_addr_i   = wa;
      bus.w_mem_data_i   = wd;
      bus.r_mem_addr_i   = ra;
      bus.data_type_i    = dt;
      @(posedge clk); #1;
      bus.mem_enable_i   = 1'b0;
      bus.w_mem_enable_i = 1'b0;
      bus.r_mem_enable_i = 1'b0;
      chk("busy_in_access", {31'd0, bus.mem_busy_o}, 32'd1);
      chk("ready_in_access", {31'd0, bus.mem_ready_o}, 32'd0);
      @(posedge clk); #1;
      chk("ready_in_resp", {31'd0, bus.mem_ready_o}, 32'd1);
      rdata = bus.r_mem_data_o;
      rerr  = bus.mem_err_o;
      @(posedge clk); #1;
      chk("ready_after_resp", {31'd0, bus.mem_ready_o}, 32'd0);
      chk("busy_after_resp", {31'd0, bus.mem_busy_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] d, ed, old30;
      logic e, ee;
      int rdy_cnt, idle_cnt;

      vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h10,  DT_W,  32'h0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'h10,  32'h0,        32'h10,  DT_W,  32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h20,  32'h11223344, 32'h20,  DT_W,  32'h0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h21,  32'h000000AA, 32'h21,  DT_B,  32'h0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h20,  32'h0, 32'h20, DT_W,  LANE ? 32'h1122AA44 : 32'h000000AA, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h21,  32'h0, 32'h21, DT_B,  LANE ? 32'hFFFFFFAA : 32'h000000AA, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h21,  32'h0, 32'h21, DT_BU, 32'h000000AA, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'h20,  32'h0, 32'h20, DT_H,  LANE ? 32'hFFFFAA44 : 32'h000000AA, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'h22,  32'h0, 32'h22, DT_HU, LANE ? 32'h00001122 : 32'h000000AA, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h23,  32'h0000BEEF, 32'h23, DT_H, 32'h0, LANE};
      vecs[10] = '{1'b0, 1'b1, 32'h20,  32'h0, 32'h20, DT_W,  LANE ? 32'h1122AA44 : 32'h0000BEEF, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'h21,  32'h0, 32'h21, DT_W,  LANE ? 32'h0 : 32'h0000BEEF, LANE};
      vecs[12] = '{1'b0, 1'b1, 32'h100, 32'h0, 32'h100, DT_W, 32'h0, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 32'h104, 32'h12345678, 32'h104, DT_W, 32'h0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 32'h10,  32'h0, 32'h10, 3'd3,  32'h0, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 32'h40,  32'h1, 32'h40, DT_W,  32'h0, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 32'h40,  32'h2, 32'h40, DT_W,  32'h1, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 32'h40,  32'h0, 32'h40, DT_W,  32'h2, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 32'h10,  32'h0, 32'h10, 3'd7,  32'h0, 1'b1};

      bus.mem_enable_i = 1'b0; bus.w_mem_enable_i = 1'b0; bus.r_mem_enable_i = 1'b0;
      bus.w_mem_addr_i = 32'd0; bus.w_mem_data_i = 32'd0; bus.r_mem_addr_i = 32'd0;
      bus.data_type_i = 3'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", bus.r_mem_data_o, 32'd0);
      chk("reset_ready", {31'd0, bus.mem_ready_o}, 32'd0);
      chk("reset_busy", {31'd0, bus.mem_busy_o}, 32'd0);
      chk("reset_err", {31'd0, bus.mem_err_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Fill the whole array so every later read has a defined value.
      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         model_req(1'b1, 1'b0, 32'(i * 4), d, 32'd0, DT_W, ed, ee);
         issue(1'b1, 1'b0, 32'(i * 4), d, 32'd0, DT_W, d, e);
         chk("init_write_err", {31'd0, e}, {31'd0, ee});
      end

      // Directed vector table.
      for (int i = 0; i < 19; i++) begin
         model_req(vecs[i].we, vecs[i].re, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].dt, ed, ee);
         issue(vecs[i].we, vecs[i].re, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].dt, d, e);
         chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      end

      // mem_enable_i held high across busy: one ready per accept (accepts every 3 cycles).
      @(negedge clk);
      bus.mem_enable_i = 1'b1; bus.r_mem_enable_i = 1'b1; bus.w_mem_enable_i = 1'b0;
      bus.r_mem_addr_i = 32'h10; bus.data_type_i = DT_W;
      rdy_cnt = 0; idle_cnt = 0;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1;
         if (bus.mem_ready_o) rdy_cnt++;
         if (!bus.mem_busy_o) idle_cnt++;
      end
      bus.mem_enable_i = 1'b0; bus.r_mem_enable_i = 1'b0;
      chk("held_enable_ready_count", 32'(rdy_cnt), 32'd3);
      chk("held_enable_idle_count", 32'(idle_cnt), 32'd3);

      // Reset during the ACCESS cycle of a write to 0x30: write must be dropped.
      old30 = model_mem[12];
      @(negedge clk);
      bus.mem_enable_i = 1'b1; bus.w_mem_enable_i = 1'b1; bus.r_mem_enable_i = 1'b0;
      bus.w_mem_addr_i = 32'h30; bus.w_mem_data_i = 32'h55; bus.data_type_i = DT_W;
      @(posedge clk); #1;
      bus.mem_enable_i = 1'b0; bus.w_mem_enable_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_access_ready", {31'd0, bus.mem_ready_o}, 32'd0);
      chk("rst_access_busy", {31'd0, bus.mem_busy_o}, 32'd0);
      chk("rst_access_err", {31'd0, bus.mem_err_o}, 32'd0);
      chk("rst_access_data", bus.r_mem_data_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h30, DT_W, d, e);
      chk("rst_write_dropped", d, old30);
      chk("rst_write_dropped_err", {31'd0, e}, 32'd0);

      // Random requests against the reference model.
      for (int n = 0; n < 250; n++) begin
         logic [1:0]  kind;
         logic [31:0] wa, ra, wd;
         logic [2:0]  dt;
         kind = 2'($urandom_range(1, 3));
         wa   = 32'($urandom_range(0, 4 * DEPTH + 15));
         ra   = (($urandom_range(0, 3)) == 0) ? wa : 32'($urandom_range(0, 4 * DEPTH + 15));
         wd   = $urandom;
         dt   = 3'($urandom_range(0, 7));
         model_req(kind[0], kind[1], wa, wd, ra, dt, ed, ee);
         issue(kind[0], kind[1], wa, wd, ra, dt, d, e);
         chk($sformatf("rand%0d_data", n), d, ed);
         chk($sformatf("rand%0d_err", n), {31'd0, e}, {31'd0, ee});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, minimum 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port mem_enable_i  input  1  request strobe.
REQ-005 SHALL have port w_mem_enable_i  input  1  write request.
REQ-006 SHALL have port w_mem_addr_i  input  `mem_addr_bus  byte address for the write.
REQ-007 SHALL have port w_mem_data_i  input  `mem_data_bus  write data, LSB-aligned.
REQ-008 SHALL have port r_mem_enable_i  input  1  read request.
REQ-009 SHALL have port r_mem_addr_i  input  `mem_addr_bus  byte address for the read.
REQ-010 SHALL have port data_type_i  input  `data_type_bus  access size: byte/half/word/ubyte/uhalf codes.
REQ-011 SHALL have port r_mem_data_o  output  `mem_data_bus  read data, LSB-aligned.
REQ-012 SHALL have port mem_ready_o  output  1  one-cycle response pulse.
REQ-013 SHALL have port mem_busy_o  output  1  high when not in IDLE; requests ignored.
REQ-014 SHALL have port mem_err_o  output  1  error flag, valid with mem_ready_o.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one request in flight.
REQ-016 SHALL accept a request in IDLE when mem_enable_i=1 and at least one of w/r enable is 1; capture all inputs; go to ACCESS.
REQ-017 SHALL ignore mem_enable_i in ACCESS and RESP; no queueing.
REQ-018 SHALL perform the array access in ACCESS: read first, then commit the write at the end of ACCESS.
REQ-019 SHALL pulse mem_ready_o for exactly the RESP cycle, 2 cycles after the accept edge.
REQ-020 SHALL update r_mem_data_o at the RESP edge and hold it until the next RESP.
REQ-021 SHALL, when both read and write are requested, return pre-write data (read-before-write).
REQ-022 SHALL use word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-023 SHALL treat addr >= 4*DEPTH_WORDS as out of range: no write, read data 0, mem_err_o=1 at RESP.
REQ-024 SHALL treat an unrecognised data_type_i code as an error: no write, read data 0, mem_err_o=1.
REQ-025 SHALL return read-only r_mem_data_o as 0 for write-only requests.
REQ-026 SHALL leave memory contents undefined at power-up.

Reset
REQ-027 SHALL drive state IDLE, r_mem_data_o=0, mem_ready_o=0, mem_busy_o=0, mem_err_o=0 on rst.
REQ-028 SHALL let rst override all activity; a write whose ACCESS cycle coincides with rst is not committed.
REQ-029 SHALL NOT clear the memory array on rst.

Configuration
REQ-030 SHALL support the macro DATA_MEM_RESP_BYTE_LANE_EN.
REQ-031 SHALL, when the macro is defined, write only the addressed lanes:
- byte: lane addr[1:0]
- half: lanes addr[1]*2 +1:0
- word: all four lanes
REQ-032 SHALL, when the macro is defined, right-shift read data by the byte offset. ubyte/uhalf zero-extend; byte/half sign-extend from bit 7/15.
REQ-033 SHALL, when the macro is defined, flag misalignment with mem_err_o=1 and suppress the write: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-034 SHALL, when the macro is undefined:
- ignore addr[1:0]
- write all 32 bits for every data type
- return the raw word
- perform no misalignment check

Verification
REQ-035 SHALL cover: word write 0xDEADBEEF @0x10, then word read @0x10 -> ready 2 cycles after each accept, data 0xDEADBEEF, err=0.
REQ-036 SHALL cover (macro on): word 0x11223344 @0x20, byte write 0xAA @0x21, word read @0x20 -> 0x1122AA44; byte read @0x21 -> 0xFFFFFFAA; ubyte read -> 0x000000AA.
REQ-037 SHALL cover: half write @0x23 (macro on) -> err=1, word @0x20 unchanged; same stimulus with macro off -> full word written, err=0.
REQ-038 SHALL cover: read @4*DEPTH_WORDS -> data 0, err=1; mem_enable_i held high during busy -> exactly one ready per accept.
REQ-039 SHALL cover: rst asserted during ACCESS of a write 0x55 @0x30 -> outputs 0 next cycle, later read @0x30 returns old value.
REQ-040 SHALL cover: simultaneous read and write @0x40 (old 0x1, new 0x2) -> r_mem_data_o=0x1, subsequent read 0x2.
